// File: rtl/verin_avalon_ram_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port RAM with 1-cycle read latency.
// Round-robin grant, freeze gate, out-of-range filtering and a sticky error flag.
module verin_avalon_ram_arbiter #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DEPTH  = 5000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              freeze,
  input  logic              err_clr,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [3:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,

  output logic              oob_err
);

  logic req0, req1, gnt0, gnt1, accept, sel;
  logic sel_read, sel_write, in_range, is_rd, oob_set;
  logic last_gnt_q, rd_pend_q, rd_owner_q, rd_oob_q, oob_err_q;

  // Grant is purely combinational; last_gnt breaks ties toward the other master.
  always_comb begin
    req0   = m0_read | m0_write;
    req1   = m1_read | m1_write;
    gnt0   = !freeze && req0 && (!req1 || last_gnt_q);
    gnt1   = !freeze && req1 && (!req0 || !last_gnt_q);
    accept = gnt0 | gnt1;
    sel    = gnt1;

    sel_read       = sel ? m1_read       : m0_read;
    sel_write      = sel ? m1_write      : m0_write;
    mem_address    = sel ? m1_address    : m0_address;
    mem_byteenable = sel ? m1_byteenable : m0_byteenable;
    mem_writedata  = sel ? m1_writedata  : m0_writedata;

    in_range = 32'(mem_address) < DEPTH;
    // read+write together counts as a write
    is_rd    = sel_read && !sel_write;
    oob_set  = accept && (!in_range || (sel_read && sel_write));

    mem_chipselect = accept && in_range;
    mem_write      = accept && in_range && sel_write;
    mem_clken      = 1'b1;

    m0_waitrequest = req0 && !gnt0;
    m1_waitrequest = req1 && !gnt1;
  end

  always_comb begin
    m0_readdatavalid = rd_pend_q && !rd_owner_q;
    m1_readdatavalid = rd_pend_q && rd_owner_q;
    m0_readdata      = (m0_readdatavalid && !rd_oob_q) ? mem_readdata : 32'h0;
    m1_readdata      = (m1_readdatavalid && !rd_oob_q) ? mem_readdata : 32'h0;
    oob_err          = oob_err_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt_q <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      rd_oob_q   <= 1'b0;
      oob_err_q  <= 1'b0;
    end else begin
      if (accept) last_gnt_q <= sel;
      rd_pend_q <= accept && is_rd;
      if (accept && is_rd) begin
        rd_owner_q <= sel;
        rd_oob_q   <= !in_range;
      end
      // a new error event wins over a simultaneous clear
      if (oob_set)      oob_err_q <= 1'b1;
      else if (err_clr) oob_err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_verin_avalon_ram_arbiter.sv
// Directed bench for verin_avalon_ram_arbiter: stimulus tasks push expected reads into a
// scoreboard queue, a negedge monitor pops and checks them against every readdatavalid.
module tb_verin_avalon_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        freeze = 1'b0, err_clr = 1'b0;
  logic [12:0] m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken, oob_err;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;

  verin_avalon_ram_arbiter #(.ADDR_W(13), .DEPTH(5000)) dut (
    .clk(clk), .reset_n(reset_n), .freeze(freeze), .err_clr(err_clr),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata), .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  // RAM model: byte-lane writes, registered read data one cycle after issue
  logic [31:0] ram [0:8191];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          owner;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every readdatavalid must match the oldest expected read
  always @(negedge clk) begin
    if (reset_n && (m0_readdatavalid || m1_readdatavalid)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got m0v=%b m1v=%b want none", m0_readdatavalid,
                 m1_readdatavalid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dual_valid", 32'(m0_readdatavalid & m1_readdatavalid), 32'd0);
        chk("rd_owner", 32'(m1_readdatavalid), 32'(e.owner));
        chk("rd_data", e.owner ? m1_readdata : m0_readdata, e.data);
        chk("other_rdata_zero", e.owner ? m0_readdata : m1_readdata, 32'h0);
        chk("rd_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  // One access on master m, held until accepted; exp_cs is the expected mem_chipselect.
  task automatic access(input bit m, input bit rd, input bit wr, input logic [12:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_cs);
    bit ok;
    @(negedge clk);
    if (m) begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
    end else begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!(m ? m1_waitrequest : m0_waitrequest)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept_timeout", 32'(ok), 32'd1);
    chk("mem_chipselect", 32'(mem_chipselect), 32'(exp_cs));
    if (rd && !wr) sb.push_back('{owner: m, data: exp_rd, due: cyc + 1});
    @(posedge clk);
    #1;
    if (m) begin m1_read = 1'b0; m1_write = 1'b0; end
    else begin m0_read = 1'b0; m0_write = 1'b0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_m0_valid", 32'(m0_readdatavalid), 32'd0);
    chk("rst_m1_valid", 32'(m1_readdatavalid), 32'd0);
    chk("rst_chipselect", 32'(mem_chipselect), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_oob_err", 32'(oob_err), 32'd0);
    chk("mem_clken", 32'(mem_clken), 32'd1);
    reset_n = 1'b1;

    // Write then read back on m0
    access(0, 0, 1, 13'h010, 4'hF, 32'hDEADBEEF, '0, 1);
    access(0, 1, 0, 13'h010, 4'hF, '0, 32'hDEADBEEF, 1);

    // Byte-enable merge on m1
    access(1, 0, 1, 13'd5, 4'hF, 32'h12345678, '0, 1);
    access(1, 0, 1, 13'd5, 4'h3, 32'h0000AAAA, '0, 1);
    access(1, 1, 0, 13'd5, 4'hF, '0, 32'h1234AAAA, 1);

    // Read+write together acts as a write and flags an error
    access(1, 1, 1, 13'd7, 4'hF, 32'h00000055, '0, 1);
    chk("rw_conflict_oob", 32'(oob_err), 32'd1);
    access(0, 1, 0, 13'd7, 4'hF, '0, 32'h00000055, 1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("oob_cleared_1", 32'(oob_err), 32'd0);

    // Out-of-range write and read
    access(0, 0, 1, 13'd5000, 4'hF, 32'hFFFFFFFF, '0, 0);
    access(0, 1, 0, 13'd6000, 4'hF, '0, 32'h0, 0);
    chk("oob_set", 32'(oob_err), 32'd1);
    repeat (2) @(negedge clk);
    chk("oob_sticky", 32'(oob_err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("oob_cleared_2", 32'(oob_err), 32'd0);
    access(0, 1, 0, 13'd4999, 4'hF, '0, 32'h0, 1);
    chk("last_word_no_oob", 32'(oob_err), 32'd0);

    // Set wins over a simultaneous clear
    err_clr = 1'b1;
    access(1, 0, 1, 13'd5000, 4'hF, '0, '0, 0);
    chk("set_wins_clr", 32'(oob_err), 32'd1);
    err_clr = 1'b0;
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;

    // Freeze: pending read completes, m1 stalls until freeze drops
    access(0, 1, 0, 13'h010, 4'hF, '0, 32'hDEADBEEF, 1);
    freeze = 1'b1; m1_read = 1'b1; m1_address = 13'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("freeze_m1_wait", 32'(m1_waitrequest), 32'd1);
      chk("freeze_no_cs", 32'(mem_chipselect), 32'd0);
    end
    freeze = 1'b0;
    #1;
    chk("unfreeze_m1_wait", 32'(m1_waitrequest), 32'd0);
    sb.push_back('{owner: 1'b1, data: 32'h1234AAAA, due: cyc + 1});
    @(posedge clk); #1 m1_read = 1'b0;

    // Reset with a read in flight; oob_err is set first so the reset must clear it
    access(0, 0, 1, 13'd5000, 4'hF, '0, '0, 0);
    @(negedge clk);
    m0_read = 1'b1; m0_address = 13'h010;
    #1 chk("pre_rst_accept", 32'(m0_waitrequest), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b0; m0_read = 1'b0;
    @(negedge clk);
    chk("rst_discard_valid", 32'(m0_readdatavalid), 32'd0);
    chk("rst_oob_clear", 32'(oob_err), 32'd0);
    @(negedge clk);

    // Release; both read continuously: m0 first, then strict alternation
    reset_n = 1'b1;
    m0_read = 1'b1; m0_address = 13'h010;
    m1_read = 1'b1; m1_address = 13'd5;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_m0_wait", 32'(m0_waitrequest), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_m1_wait", 32'(m1_waitrequest), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_chipselect", 32'(mem_chipselect), 32'd1);
      if (i % 2 == 0) sb.push_back('{owner: 1'b0, data: 32'hDEADBEEF, due: cyc + 1});
      else            sb.push_back('{owner: 1'b1, data: 32'h1234AAAA, due: cyc + 1});
      @(negedge clk);
    end
    m0_read = 1'b0; m1_read = 1'b0;
    #1 chk("idle_chipselect", 32'(mem_chipselect), 32'd0);

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
